// File: rtl/mem_access.sv
// mem_access: MEM stage of the 5-stage MIPS32 pipeline.
// Runs loads/stores over a req/ack data bus with a timeout abort, formats load
// data (big-endian lanes, sign/zero extension), and passes non-memory
// instructions straight through to the MEM/WB register.
//
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   wdata/waddr/wr_en   EX/MEM result, destination, write enable
//   memop               memory operation code (LB..SW, others = none)
//   mem_addr            effective address
//   flush               squash the current instruction
//   mem_wdata/waddr/wr_en  combinational result to MEM/WB
//   stall_req           combinational stall while an access is outstanding
//   exc_misalign        combinational misaligned-access pulse
//   exc_buserr          combinational bus-timeout pulse
//   dbus_*              registered data-bus master (req/we/sel/addr/wdata),
//                       dbus_ack/dbus_rdata from the slave
module mem_access #(
  // Legal range 2..255: REQ cycles allowed without ack before aborting.
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wdata,
  input  logic [4:0]  waddr,
  input  logic        wr_en,
  input  logic [3:0]  memop,
  input  logic [31:0] mem_addr,
  input  logic        flush,
  output logic [31:0] mem_wdata,
  output logic [4:0]  mem_waddr,
  output logic        mem_wr_en,
  output logic        stall_req,
  output logic        exc_misalign,
  output logic        exc_buserr,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);

  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] OP_LB  = 4'h1;
  localparam logic [3:0] OP_LBU = 4'h2;
  localparam logic [3:0] OP_LH  = 4'h3;
  localparam logic [3:0] OP_LHU = 4'h4;
  localparam logic [3:0] OP_LW  = 4'h5;
  localparam logic [3:0] OP_SB  = 4'h6;
  localparam logic [3:0] OP_SH  = 4'h7;
  localparam logic [3:0] OP_SW  = 4'h8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             discard_q;
  logic [3:0]       op_q;
  logic [1:0]       off_q;
  logic [DW-1:0]    result_q;
  logic             req_q;
  logic             we_q;
  logic [3:0]       sel_q;
  logic [DW-1:0]    addr_q;
  logic [DW-1:0]    bwdata_q;

  logic             op_valid_c;
  logic             op_load_c;
  logic             misalign_c;
  logic             start_c;
  logic [3:0]       sel_c;
  logic [DW-1:0]    bwdata_c;
  logic [1:0]       off_c;
  logic             done_load_c;

  // Select the addressed byte/halfword (offset 0 = bits 31:24) and extend it.
  function automatic logic [DW-1:0] fmt_load(input logic [3:0]    op,
                                             input logic [1:0]    off,
                                             input logic [DW-1:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rd[31:24];
      2'd1:    b = rd[23:16];
      2'd2:    b = rd[15:8];
      default: b = rd[7:0];
    endcase
    h = off[1] ? rd[15:0] : rd[31:16];
    case (op)
      OP_LB:   fmt_load = {{24{b[7]}}, b};
      OP_LBU:  fmt_load = {24'd0, b};
      OP_LH:   fmt_load = {{16{h[15]}}, h};
      OP_LHU:  fmt_load = {16'd0, h};
      default: fmt_load = rd;
    endcase
  endfunction

  // Decode the presented memop: validity, direction, alignment, lanes, store data.
  always_comb begin
    off_c      = mem_addr[1:0];
    op_valid_c = 1'b0;
    op_load_c  = 1'b0;
    misalign_c = 1'b0;
    sel_c      = 4'b0000;
    bwdata_c   = '0;
    case (memop)
      OP_LB, OP_LBU: begin
        op_valid_c = 1'b1;
        op_load_c  = 1'b1;
        sel_c      = 4'b1000 >> off_c;
      end
      OP_LH, OP_LHU: begin
        op_valid_c = 1'b1;
        op_load_c  = 1'b1;
        misalign_c = off_c[0];
        sel_c      = off_c[1] ? 4'b0011 : 4'b1100;
      end
      OP_LW: begin
        op_valid_c = 1'b1;
        op_load_c  = 1'b1;
        misalign_c = |off_c;
        sel_c      = 4'b1111;
      end
      OP_SB: begin
        op_valid_c = 1'b1;
        sel_c      = 4'b1000 >> off_c;
        bwdata_c   = {4{wdata[7:0]}};
      end
      OP_SH: begin
        op_valid_c = 1'b1;
        misalign_c = off_c[0];
        sel_c      = off_c[1] ? 4'b0011 : 4'b1100;
        bwdata_c   = {2{wdata[15:0]}};
      end
      OP_SW: begin
        op_valid_c = 1'b1;
        misalign_c = |off_c;
        sel_c      = 4'b1111;
        bwdata_c   = wdata;
      end
      default: ;
    endcase
  end

  assign start_c = (state_q == S_IDLE) && op_valid_c && !misalign_c && !flush;

  // Access FSM with registered bus master signals. The op and byte offset are
  // captured at request time so formatting never depends on the held inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      discard_q <= 1'b0;
      op_q      <= 4'd0;
      off_q     <= 2'd0;
      result_q  <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= 4'd0;
      addr_q    <= '0;
      bwdata_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_c) begin
            state_q   <= S_REQ;
            req_q     <= 1'b1;
            we_q      <= !op_load_c;
            sel_q     <= sel_c;
            addr_q    <= {mem_addr[31:2], 2'b00};
            bwdata_q  <= bwdata_c;
            op_q      <= memop;
            off_q     <= off_c;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            discard_q <= 1'b0;
          end
        end
        S_REQ: begin
          if (flush) begin
            discard_q <= 1'b1;
          end
          if (dbus_ack) begin
            req_q    <= 1'b0;
            result_q <= fmt_load(op_q, off_q, dbus_rdata);
            state_q  <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            // Abort: the slave is expected to tolerate the dropped request.
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          state_q   <= S_IDLE;
          err_q     <= 1'b0;
          discard_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign done_load_c = (op_q >= OP_LB) && (op_q <= OP_LW);

  // MEM/WB-facing outputs, stall and exceptions; forced to zero while in reset.
  always_comb begin
    mem_wdata    = wdata;
    mem_waddr    = waddr;
    mem_wr_en    = 1'b0;
    stall_req    = 1'b0;
    exc_misalign = 1'b0;
    exc_buserr   = 1'b0;
    if (!rst) begin
      mem_wdata = '0;
      mem_waddr = 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!op_valid_c) begin
            mem_wr_en = wr_en && !flush;
          end else if (!flush) begin
            if (misalign_c) begin
              exc_misalign = 1'b1;
            end else begin
              stall_req = 1'b1;
            end
          end
        end
        S_REQ: begin
          stall_req = 1'b1;
        end
        S_DONE: begin
          mem_wdata = done_load_c ? result_q : wdata;
          if (!flush && !discard_q) begin
            if (err_q) begin
              exc_buserr = 1'b1;
            end else begin
              mem_wr_en = done_load_c && wr_en;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_sel   = sel_q;
  assign dbus_addr  = addr_q;
  assign dbus_wdata = bwdata_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: self-checking bench for mem_access. Each instruction is
// applied with a chosen slave ack delay and flush pattern; expected outputs are
// derived from access size, byte offset and extension rules.
module tb_mem_access;

  localparam int T = 4;

  logic        clk;
  logic        rst;
  logic [31:0] wdata;
  logic [4:0]  waddr;
  logic        wr_en;
  logic [3:0]  memop;
  logic [31:0] mem_addr;
  logic        flush;
  logic [31:0] mem_wdata;
  logic [4:0]  mem_waddr;
  logic        mem_wr_en;
  logic        stall_req;
  logic        exc_misalign;
  logic        exc_buserr;
  logic        dbus_req;
  logic        dbus_we;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  int n_vec;
  int n_err;

  mem_access #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .wdata(wdata), .waddr(waddr), .wr_en(wr_en), .memop(memop),
    .mem_addr(mem_addr), .flush(flush),
    .mem_wdata(mem_wdata), .mem_waddr(mem_waddr), .mem_wr_en(mem_wr_en),
    .stall_req(stall_req), .exc_misalign(exc_misalign), .exc_buserr(exc_buserr),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_sel(dbus_sel),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Access size in bytes; 0 means not a memory op.
  function automatic int op_bytes(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'h6: op_bytes = 1;
      4'h3, 4'h4, 4'h7: op_bytes = 2;
      4'h5, 4'h8:       op_bytes = 4;
      default:          op_bytes = 0;
    endcase
  endfunction

  // Apply one instruction. d = REQ cycle index in which the slave acks
  // (d >= T means never). Flush can be pulsed in IDLE, first REQ cycle, or DONE.
  task automatic run_instr(input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] wa,
                           input logic we, input int d, input bit fl_idle,
                           input bit fl_req, input bit fl_done,
                           input logic [31:0] rd);
    int n, off, nreq, sh;
    bit ld, sgn, mis, acc, tmo;
    logic [3:0]  esel;
    logic [31:0] ebwd, eld, mask;
    n    = op_bytes(op);
    ld   = (op >= 4'h1) && (op <= 4'h5);
    sgn  = (op == 4'h1) || (op == 4'h3);
    off  = int'(addr % 4);
    mis  = (n != 0) && ((addr % n) != 0);
    acc  = (n != 0) && !mis && !fl_idle;
    tmo  = (d >= T);
    nreq = tmo ? T : d + 1;
    esel = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + n) esel[3 - i] = 1'b1;
    end
    ebwd = (n == 1) ? wd[7:0] * 32'h01010101 :
           (n == 2) ? wd[15:0] * 32'h00010001 : wd;
    if (n > 0 && n < 4) begin
      sh   = 8 * (4 - off - n);
      mask = (32'd1 << (8 * n)) - 32'd1;
      eld  = (rd >> sh) & mask;
      if (sgn && eld[8 * n - 1]) eld = eld | ~mask;
    end else begin
      eld = rd;
    end

    @(posedge clk); #1;
    memop = op; mem_addr = addr; wdata = wd; waddr = wa; wr_en = we;
    flush = fl_idle; dbus_ack = 1'($urandom_range(0, 1)); dbus_rdata = $urandom();
    @(negedge clk);
    check("idle_req", dbus_req, 0);
    check("idle_stall", stall_req, acc);
    check("idle_buserr", exc_buserr, 0);
    if (!acc) begin
      check("idle_wr_en", mem_wr_en, (n == 0) ? (we && !fl_idle) : 0);
      check("idle_waddr", mem_waddr, wa);
      check("misalign", exc_misalign, mis && !fl_idle);
      if (!fl_idle) check("idle_wdata", mem_wdata, wd);
      return;
    end
    check("start_wr_en", mem_wr_en, 0);
    check("start_misalign", exc_misalign, 0);

    for (int k = 0; k < nreq; k++) begin
      @(posedge clk); #1;
      flush      = fl_req && (k == 0);
      dbus_ack   = (k == d);
      dbus_rdata = (k == d) ? rd : $urandom();
      @(negedge clk);
      check("req", dbus_req, 1);
      check("req_stall", stall_req, 1);
      check("req_addr", dbus_addr, {addr[31:2], 2'b00});
      check("req_sel", 32'(esel), 32'(dbus_sel) == 32'(esel) ? 32'(dbus_sel) : 32'(esel));
      check("req_sel_v", 32'(dbus_sel), 32'(esel));
      check("req_we", dbus_we, !ld);
      if (!ld) check("req_wdata", dbus_wdata, ebwd);
      check("req_wr_en", mem_wr_en, 0);
    end

    @(posedge clk); #1;
    flush = fl_done; dbus_ack = 1'($urandom_range(0, 1)); dbus_rdata = $urandom();
    @(negedge clk);
    check("done_req", dbus_req, 0);
    check("done_stall", stall_req, 0);
    check("done_waddr", mem_waddr, wa);
    check("done_wr_en", mem_wr_en, ld && we && !tmo && !fl_req && !fl_done);
    check("done_buserr", exc_buserr, tmo && !fl_req && !fl_done);
    check("done_misalign", exc_misalign, 0);
    if (!ld) check("done_wdata", mem_wdata, wd);
    else if (!tmo) check("done_ldata", mem_wdata, eld);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0; flush = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'hDEADBEEF;
    memop = 4'h5; mem_addr = 32'h40; wdata = 32'h1234; waddr = 5'd7; wr_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req", dbus_req, 0);
    check("rst_we", dbus_we, 0);
    check("rst_sel", 32'(dbus_sel), 0);
    check("rst_addr", dbus_addr, 0);
    check("rst_bwdata", dbus_wdata, 0);
    check("rst_stall", stall_req, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_waddr", 32'(mem_waddr), 0);
    check("rst_exc", 32'({exc_misalign, exc_buserr}), 0);
    @(posedge clk); #1;
    rst = 1'b1; memop = 4'h0;

    // Directed cases
    run_instr(4'h0, 32'h0,   32'h1234,     5'd5, 1'b1, 0,  0, 0, 0, 32'h0);
    run_instr(4'h1, 32'h103, 32'h0,        5'd3, 1'b1, 0,  0, 0, 0, 32'h112233F0);
    run_instr(4'h7, 32'h202, 32'hAAAABEEF, 5'd0, 1'b0, 2,  0, 0, 0, 32'h0);
    run_instr(4'h5, 32'h2,   32'h55,       5'd9, 1'b1, 0,  0, 0, 0, 32'h0);
    run_instr(4'h5, 32'h300, 32'h0,        5'd4, 1'b1, 10, 0, 0, 0, 32'h0);
    run_instr(4'h4, 32'h10,  32'h0,        5'd6, 1'b1, 1,  0, 1, 0, 32'h80011234);
    run_instr(4'h3, 32'h12,  32'h0,        5'd6, 1'b1, 0,  0, 0, 0, 32'h1234F00D);
    run_instr(4'h2, 32'h21,  32'h0,        5'd8, 1'b1, 3,  0, 0, 0, 32'h00A50000);
    run_instr(4'h6, 32'h31,  32'h123456C3, 5'd8, 1'b1, 1,  0, 0, 0, 32'h0);
    run_instr(4'h8, 32'h40,  32'hCAFEF00D, 5'd8, 1'b1, 0,  0, 0, 0, 32'h0);
    run_instr(4'h5, 32'h44,  32'h0,        5'd2, 1'b1, 0,  1, 0, 0, 32'h0);
    run_instr(4'hF, 32'h44,  32'h77,       5'd2, 1'b1, 0,  0, 0, 0, 32'h0);

    // Reset in the middle of a REQ
    @(posedge clk); #1;
    memop = 4'h5; mem_addr = 32'h80; wr_en = 1'b1; waddr = 5'd11; flush = 1'b0; dbus_ack = 1'b0;
    @(posedge clk); #1;
    check("mid_req_before", dbus_req, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_req", dbus_req, 0);
    check("mid_rst_stall", stall_req, 0);
    check("mid_rst_wr_en", mem_wr_en, 0);
    @(posedge clk); #1;
    rst = 1'b1; memop = 4'h0;
    run_instr(4'h5, 32'h80, 32'h0, 5'd11, 1'b1, 0, 0, 0, 0, 32'h89ABCDEF);

    // Randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      run_instr(4'($urandom_range(0, 15)), $urandom(), $urandom(),
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 5)),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 7) == 0), $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
